// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared segment patterns and decoder FSM state type
// Purpose: active-low 7-segment patterns {g..a} as produced by the display
//          encoder, digit count, and the scan-decoder FSM state encoding.
// Ports:   none (package)
package seg7_pkg;

    localparam int N_DIGITS = 4;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        CONVERT = 2'd1,
        PUBLISH = 2'd2
    } dec_state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// rtl/seg7_pattern_decode.sv - active-low 7-segment pattern to BCD digit
// Purpose: combinational decode of one segment pattern.
// Ports:   pattern_i [6:0]  segment lines {g..a}, active low
//          legal_o          pattern is a digit 0..9 or blank
//          blank_o          pattern is all segments off
//          digit_o   [3:0]  decoded digit; 0 for blank and illegal patterns
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic       legal_o,
    output logic       blank_o,
    output logic [3:0] digit_o
);

    always_comb begin
        legal_o = 1'b1;
        blank_o = 1'b0;
        digit_o = 4'd0;
        case (pattern_i)
            SEG_0:     digit_o = 4'd0;
            SEG_1:     digit_o = 4'd1;
            SEG_2:     digit_o = 4'd2;
            SEG_3:     digit_o = 4'd3;
            SEG_4:     digit_o = 4'd4;
            SEG_5:     digit_o = 4'd5;
            SEG_6:     digit_o = 4'd6;
            SEG_7:     digit_o = 4'd7;
            SEG_8:     digit_o = 4'd8;
            SEG_9:     digit_o = 4'd9;
            SEG_BLANK: blank_o = 1'b1;
            default:   legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - rebuild the value shown on a scanned 4-digit 7-seg display
// Purpose: snoops the active-low seg/an/dp lines, captures each digit once it
//          has been stable for SETTLE cycles, assembles complete frames and
//          publishes them as binary and BCD.
// Ports:   clk, rst          clock, synchronous active-high reset
//          seg [6:0]         segment lines {g..a}, active low
//          an  [3:0]         digit enables, active low, an[0] = units
//          dp                decimal point, active low (synchronized only)
//          value [13:0]      binary value of the last published frame
//          digits [15:0]     BCD {d3,d2,d1,d0} of the last published frame
//          valid             1-cycle pulse when value/digits update
//          err               1-cycle pulse when a frame was rejected
//          stale             high when nothing was published for TIMEOUT cycles
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int SETTLE  = 8,
    parameter int TIMEOUT = 262144
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
    input  logic        dp,
    output logic [13:0] value,
    output logic [15:0] digits,
    output logic        valid,
    output logic        err,
    output logic        stale
);

    localparam int CW = $clog2(SETTLE + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [6:0]            seg_s1_q, seg_s2_q;
    logic [N_DIGITS-1:0]   an_s1_q, an_s2_q;
    logic                  dp_s1_q, dp_s2_q;
    logic [10:0]           prev_q;
    logic [CW-1:0]         stab_q, stab_d;
    logic [4*N_DIGITS-1:0] slot_q, slot_d;
    logic [N_DIGITS-1:0]   seen_q, seen_d;
    logic                  frame_bad_q, frame_bad_d;

    dec_state_t            state_q;
    logic [15:0]           conv_q;
    logic                  conv_bad_q;
    logic [13:0]           acc_q;
    logic [1:0]            step_q;
    logic [3:0]            conv_digit;
    logic [13:0]           value_q;
    logic [15:0]           digits_q;
    logic                  valid_q, err_q, stale_q;
    logic [TW-1:0]         stale_cnt_q;

    logic                  same, capture, one_hot, multi, handoff;
    logic [N_DIGITS-1:0]   an_low;
    logic                  dec_legal, dec_blank;
    logic [3:0]            dec_digit;
    logic                  dp_unused;

    // The decimal point is synchronized alongside the other lines but carries
    // no information for the readback.
    assign dp_unused = dp_s2_q;

    seg7_pattern_decode u_decode (
        .pattern_i (seg_s2_q),
        .legal_o   (dec_legal),
        .blank_o   (dec_blank),
        .digit_o   (dec_digit)
    );

    assign same    = ({seg_s2_q, an_s2_q} == prev_q);
    // stab_q counts stable cycles beyond the first; this fires on the
    // SETTLE-th identical cycle and only once, since the counter then saturates.
    assign capture = same && (stab_q == CW'(SETTLE - 2));
    assign an_low  = ~an_s2_q;
    assign one_hot = (an_low != '0) && ((an_low & (an_low - 4'd1)) == '0);
    assign multi   = (an_low != '0) && !one_hot;
    // Frame hand-off: slots move to conversion, and any capture in this same
    // cycle is counted towards the next frame.
    assign handoff = (state_q == COLLECT) && (seen_q == '1);

    always_comb begin
        stab_d = stab_q;
        if (!same) begin
            stab_d = '0;
        end else if (stab_q != CW'(SETTLE)) begin
            stab_d = stab_q + CW'(1);
        end
    end

    always_comb begin
        slot_d      = slot_q;
        seen_d      = handoff ? '0 : seen_q;
        frame_bad_d = handoff ? 1'b0 : frame_bad_q;
        if (capture) begin
            if (one_hot) begin
                for (int k = 0; k < N_DIGITS; k++) begin
                    if (an_low[k]) begin
                        slot_d[4*k +: 4] = (dec_legal && !dec_blank) ? dec_digit : 4'd0;
                        seen_d[k]        = 1'b1;
                    end
                end
                if (!dec_legal) begin
                    frame_bad_d = 1'b1;
                end
            end else if (multi) begin
                frame_bad_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_s1_q    <= SEG_BLANK;
            seg_s2_q    <= SEG_BLANK;
            an_s1_q     <= '1;
            an_s2_q     <= '1;
            dp_s1_q     <= 1'b1;
            dp_s2_q     <= 1'b1;
            prev_q      <= {SEG_BLANK, 4'hF};
            stab_q      <= '0;
            slot_q      <= '0;
            seen_q      <= '0;
            frame_bad_q <= 1'b0;
        end else begin
            seg_s1_q    <= seg;
            seg_s2_q    <= seg_s1_q;
            an_s1_q     <= an;
            an_s2_q     <= an_s1_q;
            dp_s1_q     <= dp;
            dp_s2_q     <= dp_s1_q;
            prev_q      <= {seg_s2_q, an_s2_q};
            stab_q      <= stab_d;
            slot_q      <= slot_d;
            seen_q      <= seen_d;
            frame_bad_q <= frame_bad_d;
        end
    end

    // Most significant digit first so acc*10 + d builds the binary value.
    always_comb begin
        case (step_q)
            2'd0:    conv_digit = conv_q[15:12];
            2'd1:    conv_digit = conv_q[11:8];
            2'd2:    conv_digit = conv_q[7:4];
            default: conv_digit = conv_q[3:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= COLLECT;
            conv_q      <= '0;
            conv_bad_q  <= 1'b0;
            acc_q       <= '0;
            step_q      <= '0;
            value_q     <= '0;
            digits_q    <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            stale_q     <= 1'b0;
            stale_cnt_q <= '0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            if (stale_cnt_q != TW'(TIMEOUT)) begin
                stale_cnt_q <= stale_cnt_q + TW'(1);
            end
            if (stale_cnt_q >= TW'(TIMEOUT - 1)) begin
                stale_q <= 1'b1;
            end
            case (state_q)
                COLLECT: begin
                    if (seen_q == '1) begin
                        conv_q     <= slot_q;
                        conv_bad_q <= frame_bad_q;
                        acc_q      <= '0;
                        step_q     <= '0;
                        state_q    <= CONVERT;
                    end
                end
                CONVERT: begin
                    acc_q  <= (acc_q << 3) + (acc_q << 1) + {10'd0, conv_digit};
                    step_q <= step_q + 2'd1;
                    if (step_q == 2'd3) begin
                        state_q <= PUBLISH;
                    end
                end
                PUBLISH: begin
                    if (!conv_bad_q) begin
                        value_q     <= acc_q;
                        digits_q    <= conv_q;
                        valid_q     <= 1'b1;
                        stale_cnt_q <= '0;
                        stale_q     <= 1'b0;
                    end else begin
                        err_q <= 1'b1;
                    end
                    state_q <= COLLECT;
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

    assign value  = value_q;
    assign digits = digits_q;
    assign valid  = valid_q;
    assign err    = err_q;
    assign stale  = stale_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb/tb_seg7_scan_decoder.sv - self-checking bench for seg7_scan_decoder
module tb_seg7_scan_decoder;

    localparam int SETTLE  = 8;
    localparam int TIMEOUT = 1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  seg = 7'b1111111;
    logic [3:0]  an  = 4'b1111;
    logic        dp  = 1'b1;
    logic [13:0] value;
    logic [15:0] digits;
    logic        valid, err, stale;

    seg7_scan_decoder #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .clk    (clk),
        .rst    (rst),
        .seg    (seg),
        .an     (an),
        .dp     (dp),
        .value  (value),
        .digits (digits),
        .valid  (valid),
        .err    (err),
        .stale  (stale)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] exp_q[$];
    int          exp_err = 0;
    logic [29:0] got_q[$];
    int          got_err = 0;
    logic [15:0] last_bcd = 16'h0000;

    always @(negedge clk) begin
        if (valid) got_q.push_back({value, digits});
        if (err)   got_err++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic logic [6:0] enc(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic int bcd_val(input logic [15:0] b);
        return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic show(input int k, input logic [6:0] p, input int n);
        logic [3:0] one;
        one = 4'b0001 << k;
        an  = ~one;
        seg = p;
        tick(n);
    endtask

    task automatic idle(input int n);
        an  = 4'b1111;
        seg = 7'b1111111;
        tick(n);
    endtask

    task automatic scan(input logic [15:0] b, input int dwell);
        for (int k = 0; k < 4; k++) show(k, enc(int'(b[4*k +: 4])), dwell);
        exp_q.push_back(b);
    endtask

    task automatic drain(input string tag);
        logic [29:0] g;
        logic [15:0] e;
        idle(20);
        check_eq({tag, ".nvalid"}, got_q.size(), exp_q.size());
        check_eq({tag, ".nerr"}, got_err, exp_err);
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            check_eq({tag, ".value"}, g[29:16], bcd_val(e));
            check_eq({tag, ".digits"}, g[15:0], e);
            last_bcd = e;
        end
        got_q.delete();
        exp_q.delete();
        got_err = 0;
        exp_err = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, ".value"}, value, 0);
        check_eq({tag, ".digits"}, digits, 0);
        check_eq({tag, ".valid"}, valid, 0);
        check_eq({tag, ".err"}, err, 0);
        check_eq({tag, ".stale"}, stale, 0);
    endtask

    initial begin
        int ord[4];
        int tmp, j, k;
        logic [15:0] b;
        bit lead_blank;

        tick(4);
        rst = 1'b0;
        tick(1);
        check_reset_outputs("reset");

        // 173 scanned units first
        show(0, 7'b0110000, 20);
        show(1, 7'b1111000, 20);
        show(2, 7'b1111001, 20);
        show(3, 7'b1000000, 20);
        exp_q.push_back(16'h0173);
        drain("t1");

        scan(16'h0255, 20);
        scan(16'h0000, 20);
        drain("t2");

        // short dwell on an2 must not complete the frame
        show(0, enc(3), 20);
        show(1, enc(2), 20);
        show(2, enc(9), SETTLE - 1);
        show(3, enc(1), 20);
        idle(20);
        check_eq("t3.short_dwell", got_q.size(), 0);
        show(2, enc(6), SETTLE);
        exp_q.push_back(16'h1623);
        drain("t3");

        show(0, enc(5), 20);
        show(1, 7'b1010101, 20);
        show(2, enc(1), 20);
        show(3, enc(0), 20);
        exp_err = 1;
        drain("t4");
        check_eq("t4.hold_value", value, bcd_val(last_bcd));
        check_eq("t4.hold_digits", digits, last_bcd);

        an  = 4'b0011;
        seg = enc(8);
        tick(20);
        show(0, enc(2), 20);
        show(1, enc(4), 20);
        show(2, enc(0), 20);
        show(3, enc(0), 20);
        exp_err = 1;
        drain("t5a");
        check_eq("t5.hold_value", value, bcd_val(last_bcd));
        scan(16'h0042, 20);
        drain("t5b");

        for (int f = 0; f < 12; f++) begin
            for (int i = 0; i < 4; i++) begin
                b[4*i +: 4] = 4'($urandom_range(0, 9));
                ord[i] = i;
            end
            for (int i = 3; i > 0; i--) begin
                j = $urandom_range(0, i);
                tmp = ord[i]; ord[i] = ord[j]; ord[j] = tmp;
            end
            lead_blank = (b[15:12] == 4'd0) && ($urandom_range(0, 1) == 1);
            for (int i = 0; i < 4; i++) begin
                k = ord[i];
                if ($urandom_range(0, 3) == 0)
                    show($urandom_range(0, 3), enc($urandom_range(0, 9)), $urandom_range(1, SETTLE - 1));
                if (k == 3 && lead_blank)
                    show(k, 7'b1111111, $urandom_range(SETTLE, 25));
                else
                    show(k, enc(int'(b[4*k +: 4])), $urandom_range(SETTLE, 25));
            end
            exp_q.push_back(b);
            drain("rand");
        end

        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        got_q.delete();
        got_err = 0;
        check_reset_outputs("t6.reset");
        idle(TIMEOUT - 10);
        check_eq("t6.stale_early", stale, 0);
        idle(20);
        check_eq("t6.stale_set", stale, 1);
        scan(16'h0009, 20);
        drain("t6");
        check_eq("t6.stale_clear", stale, 0);

        // reset lands while the 5678 frame is converting
        show(0, enc(8), 20);
        show(1, enc(7), 20);
        show(2, enc(6), 20);
        an  = 4'b0111;
        seg = enc(5);
        tick(12);
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        idle(20);
        check_eq("t6.rst_nvalid", got_q.size(), 0);
        check_eq("t6.rst_nerr", got_err, 0);
        check_eq("t6.rst_value", value, 0);
        check_eq("t6.rst_digits", digits, 0);
        check_eq("t6.rst_stale", stale, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
